iomem_arb2: RTL and testbench
=============================

IOMEM_ARB2 -- requirements
Module: iomem_arb2

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning target wait limit in cycles (legal 1..255).
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF, meaning rdata returned on timeout.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 m0_valid / m1_valid  input  1  requester valid (picosoc-style iomem master).
REQ-006 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-007 m0_addr, m0_wdata / m1_addr, m1_wdata  input  32  address, write data.
REQ-008 m0_ready / m1_ready  output  1  one-cycle completion pulse.
REQ-009 m0_rdata / m1_rdata  output  32  read data, valid while mX_ready=1.
REQ-010 s_valid  output  1  target request.
REQ-011 s_wstrb  output  4; s_addr, s_wdata  output  32  registered copy of the granted request.
REQ-012 s_ready  input  1; s_rdata  input  32  target completion and read data.
REQ-013 grant  output  1  owner of the current or last transaction (0 = m0, 1 = m1).
REQ-014 err_flag  output  1  sticky timeout indicator; err_clr  input  1  clears it.

Function
REQ-015 States: IDLE, BUSY, RESP only; any other encoding recovers to IDLE on the next edge.
REQ-016 IDLE, exactly one valid: latch that master's addr/wdata/wstrb, set grant, enter BUSY.
REQ-017 IDLE, both valid: grant the master not granted last (round-robin); after reset m0 wins first.
REQ-018 IDLE, no valid: stay in IDLE; s_valid=0.
REQ-019 BUSY: s_valid=1, with s_addr/s_wdata/s_wstrb held constant from the latched copy.
REQ-020 BUSY, s_ready=1: capture s_rdata, enter RESP; s_valid deasserts on the same edge.
REQ-021 RESP: granted mX_ready=1 for exactly one cycle with captured rdata; the other master's ready stays 0; then IDLE.
REQ-022 Latency: valid seen in IDLE at cycle N gives s_valid at N+1; s_ready at cycle M gives mX_ready at M+1; minimum 3 cycles per transaction.
REQ-023 Masters drop valid on the edge on which ready is sampled high; the block does not re-serve a master whose valid is low in IDLE.
REQ-024 A master dropping valid during BUSY does not abort; the transaction completes and the ready pulse is still issued.
REQ-025 An 8-bit wait counter clears on BUSY entry and increments each BUSY cycle with s_ready=0.
REQ-026 Timeout: counter reaches TIMEOUT-1 with s_ready=0 -> enter RESP, rdata=ERR_DATA, s_valid drops, err_flag set.
REQ-027 s_ready=1 in the same cycle as timeout: normal completion wins; err_flag unchanged.
REQ-028 err_clr=1 clears err_flag; simultaneous set and clear: set wins.
REQ-029 mX_rdata is 0 whenever mX_ready=0.
REQ-030 s_ready and s_rdata are ignored outside BUSY.

Reset
REQ-031 resetn=0 immediately forces IDLE, grant=1 (so m0 wins first), counter=0, err_flag=0.
REQ-032 During reset, all outputs are 0: s_valid, s_addr, s_wdata, s_wstrb, both mX_ready and both mX_rdata.
REQ-033 Reset mid-BUSY or mid-RESP abandons the transaction; no ready pulse is issued after release.
REQ-034 Outputs stay stable from reset release until the first clk edge.

Verification
REQ-035 m0 reads addr 32'h0300_0000, target s_ready one cycle after s_valid, s_rdata=32'h1234_5678 -> m0_ready pulse 1 cycle, m0_rdata=32'h1234_5678, total 3 cycles.
REQ-036 m0 and m1 request simultaneously and repeatedly, 4 transactions -> grant order m0, m1, m0, m1.
REQ-037 m1 writes wstrb=4'b0101, wdata=32'hAABB_CCDD -> s_wstrb=4'b0101, s_wdata=32'hAABB_CCDD held stable until s_ready.
REQ-038 TIMEOUT=4, target never ready -> mX_ready after 4 BUSY cycles, rdata=32'hFFFF_FFFF, err_flag=1 until err_clr pulse.
REQ-039 resetn asserted while BUSY -> s_valid=0 asynchronously; after release, m0 and m1 both request -> m0 granted first, no stale ready.
REQ-040 s_ready=1 on the exact timeout cycle with s_rdata=32'h0000_00A5 -> rdata=32'h0000_00A5, err_flag stays 0.

Source files
------------

// File: rtl/iomem_arb2.sv
// Two-master round-robin arbiter in front of a single picosoc-style iomem target.
// Each transaction runs IDLE -> BUSY -> RESP, with a wait-cycle timeout that returns ERR_DATA.
module iomem_arb2 #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        err_flag,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        s_valid_q, s_valid_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        m0_ready_q, m0_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        err_flag_q, err_flag_d;

  logic        pick_m1;
  logic        done;
  logic        err_set;
  logic [31:0] resp_data;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    s_valid_d  = s_valid_q;
    s_wstrb_d  = s_wstrb_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    cnt_d      = cnt_q;
    m0_ready_d = 1'b0;
    m0_rdata_d = '0;
    m1_ready_d = 1'b0;
    m1_rdata_d = '0;
    pick_m1    = 1'b0;
    done       = 1'b0;
    err_set    = 1'b0;
    resp_data  = '0;

    case (state_q)
      IDLE: begin
        s_valid_d = 1'b0;
        if (m0_valid || m1_valid) begin
          // With both requesting, the master not granted last wins.
          pick_m1   = m1_valid && (!m0_valid || !grant_q);
          grant_d   = pick_m1;
          s_addr_d  = pick_m1 ? m1_addr  : m0_addr;
          s_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          s_wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
          s_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          done      = 1'b1;
          resp_data = s_rdata;
        end else if (cnt_q == TMO_LAST) begin
          done      = 1'b1;
          err_set   = 1'b1;
          resp_data = ERR_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          state_d   = RESP;
          s_valid_d = 1'b0;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = resp_data;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = resp_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
      end
    endcase

    err_flag_d = err_set | (err_flag_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= 1'b1;
      s_valid_q  <= 1'b0;
      s_wstrb_q  <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      cnt_q      <= '0;
      m0_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_ready_q <= 1'b0;
      m1_rdata_q <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      s_valid_q  <= s_valid_d;
      s_wstrb_q  <= s_wstrb_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      cnt_q      <= cnt_d;
      m0_ready_q <= m0_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_ready_q <= m1_ready_d;
      m1_rdata_q <= m1_rdata_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign grant    = grant_q;
  assign s_valid  = s_valid_q;
  assign s_wstrb  = s_wstrb_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign m0_ready = m0_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ready = m1_ready_q;
  assign m1_rdata = m1_rdata_q;
  assign err_flag = err_flag_q;

endmodule

// File: tb/tb_iomem_arb2.sv
// Directed bench for iomem_arb2 (TIMEOUT=4): inputs change and outputs are sampled on the falling edge.
module tb_iomem_arb2;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        grant;
  logic        err_flag;
  logic        err_clr;

  int n_checks = 0;
  int n_pass   = 0;
  int order [4] = '{9, 9, 9, 9};
  int got;
  int n;
  int hit;

  iomem_arb2 #(.TIMEOUT(4), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err_flag(err_flag), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  initial begin
    resetn = 1'b0; err_clr = 1'b0;
    m0_valid = 1'b0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    s_ready = 1'b0; s_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_s_valid", s_valid, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_s_wstrb", s_wstrb, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    check("rst_grant", grant, 1);
    check("rst_err_flag", err_flag, 0);
    resetn = 1'b1;

    // Basic m0 read, target answers one cycle after s_valid
    m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'b0000;
    @(negedge clk);
    check("rd_s_valid", s_valid, 1);
    check("rd_s_addr", s_addr, 32'h0300_0000);
    check("rd_s_wstrb", s_wstrb, 0);
    check("rd_grant", grant, 0);
    check("rd_m0_ready_early", m0_ready, 0);
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rd_m0_ready", m0_ready, 1);
    check("rd_m0_rdata", m0_rdata, 32'h1234_5678);
    check("rd_m1_ready", m1_ready, 0);
    check("rd_m1_rdata", m1_rdata, 0);
    check("rd_s_valid_drop", s_valid, 0);
    m0_valid = 1'b0; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rd_m0_ready_pulse", m0_ready, 0);
    check("rd_m0_rdata_zero", m0_rdata, 0);
    check("rd_idle_s_valid", s_valid, 0);
    @(negedge clk);
    check("rd_idle_ignore_s_ready", s_valid, 0);
    check("rd_idle_no_ready", m0_ready, 0);
    s_ready = 1'b0;

    // m1 write, drops valid and changes wdata mid-BUSY
    m1_valid = 1'b1; m1_addr = 32'h0300_0100; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0101;
    @(negedge clk);
    check("wr_grant", grant, 1);
    check("wr_s_valid", s_valid, 1);
    check("wr_s_wstrb", s_wstrb, 4'b0101);
    check("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
    m1_valid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 4'b0000;
    @(negedge clk);
    check("wr_hold_s_valid", s_valid, 1);
    check("wr_hold_s_wstrb", s_wstrb, 4'b0101);
    check("wr_hold_s_wdata", s_wdata, 32'hAABB_CCDD);
    check("wr_hold_s_addr", s_addr, 32'h0300_0100);
    s_ready = 1'b1; s_rdata = 32'h0000_0077;
    @(negedge clk);
    check("wr_m1_ready", m1_ready, 1);
    check("wr_m1_rdata", m1_rdata, 32'h0000_0077);
    check("wr_m0_ready", m0_ready, 0);
    s_ready = 1'b0;
    @(negedge clk);
    check("wr_m1_ready_pulse", m1_ready, 0);

    // Round robin: both request continuously, target always ready
    m0_valid = 1'b1; m0_addr = 32'h0300_0004; m0_wstrb = '0;
    m1_valid = 1'b1; m1_addr = 32'h0300_0008; m1_wstrb = '0;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (m0_ready) begin order[got] = 0; got++; end
      else if (m1_ready) begin order[got] = 1; got++; end
      if (got == 4) begin m0_valid = 1'b0; m1_valid = 1'b0; end
      s_ready = s_valid;
    end
    s_ready = 1'b0;
    check("rr_count", got, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], i % 2);
    @(negedge clk);

    // Timeout: target never ready
    m0_valid = 1'b1; m0_addr = 32'h0300_0010;
    n = 0; hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clk);
      if (m0_ready) hit = 1;
      else if (s_valid) n++;
    end
    m0_valid = 1'b0;
    check("tmo_ready", hit, 1);
    check("tmo_busy_cycles", n, 4);
    check("tmo_rdata", m0_rdata, 32'hFFFF_FFFF);
    check("tmo_err_set", err_flag, 1);
    check("tmo_s_valid_drop", s_valid, 0);
    repeat (2) @(negedge clk);
    check("tmo_err_sticky", err_flag, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("tmo_err_cleared", err_flag, 0);

    // Timeout with err_clr held high: set wins, then clear
    err_clr = 1'b1; m0_valid = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clk);
      if (m0_ready) hit = 1;
    end
    m0_valid = 1'b0;
    check("setclr_ready", hit, 1);
    check("setclr_set_wins", err_flag, 1);
    @(negedge clk);
    check("setclr_cleared", err_flag, 0);
    err_clr = 1'b0;
    @(negedge clk);

    // s_ready on the exact timeout cycle: normal completion wins
    m1_valid = 1'b1; m1_addr = 32'h0300_0020; m1_wstrb = '0;
    n = 0; hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clk);
      if (m1_ready) hit = 1;
      else if (s_valid) begin
        n++;
        if (n == 4) begin s_ready = 1'b1; s_rdata = 32'h0000_00A5; end
      end
    end
    s_ready = 1'b0; m1_valid = 1'b0;
    check("edge_ready", hit, 1);
    check("edge_busy_cycles", n, 4);
    check("edge_rdata", m1_rdata, 32'h0000_00A5);
    check("edge_err_flag", err_flag, 0);
    @(negedge clk);

    // Reset during BUSY, then both request after release
    m0_valid = 1'b1; m0_addr = 32'h0300_0030;
    @(negedge clk);
    check("arst_busy", s_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_s_valid", s_valid, 0);
    check("arst_s_addr", s_addr, 0);
    check("arst_grant", grant, 1);
    m1_valid = 1'b1; m1_addr = 32'h0300_0034;
    @(negedge clk);
    check("arst_hold_s_valid", s_valid, 0);
    check("arst_hold_m0_ready", m0_ready, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("arst_grant_m0", grant, 0);
    check("arst_s_valid_new", s_valid, 1);
    check("arst_s_addr_new", s_addr, 32'h0300_0030);
    check("arst_no_stale_m0", m0_ready, 0);
    check("arst_no_stale_m1", m1_ready, 0);
    s_ready = 1'b1; s_rdata = 32'h0000_5555;
    @(negedge clk);
    check("arst_m0_ready", m0_ready, 1);
    check("arst_m0_rdata", m0_rdata, 32'h0000_5555);
    check("arst_m1_idle", m1_ready, 0);
    m0_valid = 1'b0; s_ready = 1'b0;
    hit = 0;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clk);
      if (m1_ready) hit = 1;
      s_ready = s_valid;
    end
    s_ready = 1'b0; m1_valid = 1'b0;
    check("arst_m1_served", hit, 1);
    check("arst_m1_grant", grant, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
